// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-point FFT/IFFT datapath.
// Twiddles are Q1.15 (re, im) pairs at the default 16-bit half width.
package fft_pkg;

   localparam int HALF = 16;

   typedef struct packed {
      logic signed [HALF-1:0] re;
      logic signed [HALF-1:0] im;
   } cplx_t;

   localparam cplx_t W0 = '{re: 16'sd32767, im: 16'sd0};
   localparam cplx_t W1 = '{re: 16'sd0, im: -16'sd32767};
   localparam cplx_t W2 = '{re: -16'sd32768, im: 16'sd0};
   localparam cplx_t W3 = '{re: 16'sd0, im: 16'sd32767};

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/butterfly.sv
// Radix-2 butterfly: out0 = A + W*B, out1 = A - W*B.
// W*B is a Q1.15 complex product rounded to nearest (half up).
module butterfly #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1
);
   localparam int H = WIDTH / 2;
   localparam int P = 2 * H + 1;
   localparam logic signed [P-1:0] RND = P'(1) <<< (H - 2);

   logic signed [H-1:0] ar, ai, br, bi, wr, wi;
   logic signed [H-1:0] tr, ti;
   logic signed [H-1:0] s0r, s0i, s1r, s1i;
   logic signed [P-1:0] pr, pi;

   assign {ar, ai} = a;
   assign {br, bi} = b;
   assign {wr, wi} = w;

   always_comb begin
      pr  = P'(wr) * P'(br) - P'(wi) * P'(bi) + RND;
      pi  = P'(wr) * P'(bi) + P'(wi) * P'(br) + RND;
      tr  = H'(pr >>> (H - 1));
      ti  = H'(pi >>> (H - 1));
      s0r = ar + tr;
      s0i = ai + ti;
      s1r = ar - tr;
      s1i = ai - ti;
   end

   assign out0 = {s0r, s0i};
   assign out1 = {s1r, s1i};

endmodule

// File: rtl/ifft4_seq.sv
// Sequential 4-point inverse FFT: one butterfly time-shared over
// two radix-2 stages, 1/4 scaling by halving every operand.
module ifft4_seq
   import fft_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);
   localparam int H = WIDTH / 2;
   localparam logic [H-1:0] WMAX = {1'b0, {(H-1){1'b1}}};
   localparam logic [WIDTH-1:0] TW_W0 = {WMAX, {H{1'b0}}};
   localparam logic [WIDTH-1:0] TW_W3 = {{H{1'b0}}, WMAX};

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d, nxt;
   logic             step_q, step_d;
   logic [WIDTH-1:0] mem_q [4];
   logic [WIDTH-1:0] mem_d [4];
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       ia, ib;
   logic [WIDTH-1:0] op_a, op_b, tw, bf0, bf1;
   logic             in_fire, out_fire;

   function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
      return {$signed(x[WIDTH-1:H]) >>> 1, $signed(x[H-1:0]) >>> 1};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         cnt_q      <= '0;
         step_q     <= 1'b0;
         out_data_q <= '0;
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         out_data_q <= out_data_d;
         for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (in_fire && cnt_q == 2'd3) state_d = S1;
         S1:      if (step_q) state_d = S2;
         S2:      if (step_q) state_d = OUT;
         OUT:     if (out_fire && cnt_q == 2'd3) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == LOAD);
      out_valid = (state_q == OUT);
      out_last  = out_valid && (cnt_q == 2'd3);
   end

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign out_data = out_data_q;

   // Stage 1 pairs (0,2)/(1,3); stage 2 pairs (0,1)/(2,3).
   always_comb begin
      ia = {1'b0, step_q};
      ib = {1'b1, step_q};
      tw = TW_W0;
      if (state_q == S2) begin
         ia = {step_q, 1'b0};
         ib = {step_q, 1'b1};
         if (step_q) tw = TW_W3;
      end
      op_a = halve(mem_q[ia]);
      op_b = halve(mem_q[ib]);
   end

   butterfly #(.WIDTH(WIDTH)) u_bf (
      .a    (op_a),
      .b    (op_b),
      .w    (tw),
      .out0 (bf0),
      .out1 (bf1)
   );

   always_comb begin
      for (int i = 0; i < 4; i++) mem_d[i] = mem_q[i];
      cnt_d      = cnt_q;
      step_d     = 1'b0;
      out_data_d = out_data_q;
      nxt        = cnt_q + 2'd1;
      unique case (state_q)
         LOAD: begin
            if (in_fire) begin
               mem_d[cnt_q] = in_data;
               cnt_d        = nxt;
            end
         end
         S1, S2: begin
            mem_d[ia] = bf0;
            mem_d[ib] = bf1;
            step_d    = !step_q;
            if (state_q == S2 && step_q) out_data_d = mem_q[0];
         end
         OUT: begin
            // Results sit bit-reversed: x0,x2,x1,x3 in entries 0..3.
            if (out_fire) begin
               cnt_d = nxt;
               if (cnt_q != 2'd3) out_data_d = mem_q[{nxt[0], nxt[1]}];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ifft4_seq.sv
// Directed bench for ifft4_seq: known spectra, handshake stalls,
// and mid-frame resets, checked against hand-computed results.
module tb_ifft4_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ifft4_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cx(input int re, input int im);
      return {re[15:0], im[15:0]};
   endfunction

   task automatic send(input logic [31:0] x0, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [31:0] x3,
                       input bit gaps, input bit hold);
      logic [31:0] xs [4];
      xs = '{x0, x1, x2, x3};
      for (int k = 0; k < 4; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(1, 3);
            in_valid = 1'b0;
            repeat (g) @(negedge clk);
         end
         chk("in_ready_load", in_ready, 1'b1);
         in_valid = 1'b1;
         in_data  = xs[k];
         @(negedge clk);
      end
      in_valid = hold;
      in_data  = 32'hdead_beef;
   endtask

   task automatic recv(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3,
                       input int n, input int stall_at, input bit lat_chk);
      logic [31:0] es [4];
      int lat;
      es  = '{e0, e1, e2, e3};
      lat = 0;
      while (!out_valid && lat < 50) begin
         if (lat_chk) chk("in_ready_busy", in_ready, 1'b0);
         @(negedge clk);
         lat++;
      end
      if (lat_chk) chk("latency", lat + 1, 5);
      else chk("out_valid", out_valid, 1'b1);
      if (!out_valid) return;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               chk("stall_data", out_data, es[i]);
               chk("stall_valid", out_valid, 1'b1);
            end
            out_ready = 1'b1;
         end
         chk($sformatf("x%0d", i), out_data, es[i]);
         chk($sformatf("last%0d", i), out_last, i == 3);
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
      end
      if (n == 4) chk("post_valid", out_valid, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_last"}, out_last, 1'b0);
      chk({tag, "_out_data"}, out_data, 32'h0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst");

      // impulse in bin 0
      send(cx(400, 0), 0, 0, 0, 1'b0, 1'b0);
      recv(cx(100, 0), cx(100, 0), cx(100, 0), cx(100, 0), 4, -1, 1'b1);

      // DC spectrum
      send(cx(400, 0), cx(400, 0), cx(400, 0), cx(400, 0), 1'b0, 1'b0);
      recv(cx(400, 0), 0, 0, 0, 4, -1, 1'b1);

      // single bin 1, gappy input
      send(0, cx(400, 0), 0, 0, 1'b1, 1'b0);
      recv(cx(100, 0), cx(0, 100), cx(-100, 0), cx(0, -100), 4, -1, 1'b1);

      // round trip of x=(40+20j, 80+60j, -40, -40j), output stall
      send(cx(80, 40), cx(180, -60), cx(-80, 0), cx(-20, 100), 1'b0, 1'b0);
      recv(cx(40, 20), cx(80, 60), cx(-40, 0), cx(0, -40), 4, 1, 1'b1);

      // odd negative input checks floor halving; in_valid held high
      send(cx(-3, 0), 0, 0, 0, 1'b0, 1'b1);
      recv(cx(-1, 0), cx(-1, 0), cx(-1, 0), cx(-1, 0), 4, -1, 1'b1);

      // reset after two inputs
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_data  = cx(1000, 1000);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk_reset_vals("rst_load");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(cx(80, 40), cx(180, -60), cx(-80, 0), cx(-20, 100), 1'b0, 1'b0);
      recv(cx(40, 20), cx(80, 60), cx(-40, 0), cx(0, -40), 4, -1, 1'b1);

      // reset in OUT after x1
      send(cx(400, 0), cx(400, 0), cx(400, 0), cx(400, 0), 1'b0, 1'b0);
      recv(cx(400, 0), 0, 0, 0, 2, -1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_out");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("no_partial", out_valid, 1'b0);
      end
      send(0, cx(400, 0), 0, 0, 1'b0, 1'b0);
      recv(cx(100, 0), cx(0, 100), cx(-100, 0), cx(0, -100), 4, -1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
